// File: rtl/obstacle_pkg.sv
// Shared types for the obstacle hit detector: coordinate width, FSM states, box edges.
package obstacle_pkg;
   localparam int COORD_W = 12;

   typedef enum logic [1:0] {
      IDLE,
      ARMED,
      COOLDOWN
   } state_t;

   typedef struct packed {
      logic [COORD_W-1:0] x1;
      logic [COORD_W-1:0] x2;
      logic [COORD_W-1:0] y1;
      logic [COORD_W-1:0] y2;
   } box_t;
endpackage

// File: rtl/box_clip_reg.sv
// Snapshots one box on a frame strobe, clipped to the display, and flags
// whether the current beam position lies inside the held snapshot.
module box_clip_reg
   import obstacle_pkg::*;
#(
   parameter int D_WIDTH  = 640,
   parameter int D_HEIGHT = 480
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic               i_stb,
   input  box_t               i_box,
   input  logic [COORD_W-1:0] i_pix_x,
   input  logic [COORD_W-1:0] i_pix_y,
   output box_t               o_box,
   output logic               o_vis,
   output logic               o_inside
);
   localparam logic [COORD_W-1:0] X_MAX = COORD_W'(D_WIDTH - 1);
   localparam logic [COORD_W-1:0] Y_MAX = COORD_W'(D_HEIGHT - 1);

   box_t w_clip;
   logic w_vis;

   // A left/top edge above its right/bottom edge has wrapped below zero.
   always_comb begin
      w_clip.x1 = (i_box.x1 > i_box.x2) ? '0 : i_box.x1;
      w_clip.x2 = (i_box.x2 > X_MAX) ? X_MAX : i_box.x2;
      w_clip.y1 = (i_box.y1 > i_box.y2) ? '0 : i_box.y1;
      w_clip.y2 = (i_box.y2 > Y_MAX) ? Y_MAX : i_box.y2;
      w_vis     = (w_clip.x1 <= X_MAX) && (w_clip.y1 <= Y_MAX);
   end

   box_t r_box;
   logic r_vis;
   logic r_inside;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_box    <= '0;
         r_vis    <= 1'b0;
         r_inside <= 1'b0;
      end else begin
         if (i_stb) begin
            r_box <= w_clip;
            r_vis <= w_vis;
         end
         r_inside <= r_vis &&
                     (i_pix_x >= r_box.x1) && (i_pix_x <= r_box.x2) &&
                     (i_pix_y >= r_box.y1) && (i_pix_y <= r_box.y2);
      end
   end

   assign o_box    = r_box;
   assign o_vis    = r_vis;
   assign o_inside = r_inside;
endmodule

// File: rtl/obstacle_hit_detector.sv
// Per-frame obstacle/player overlap detector with hit cooldown and pixel flags.
// Optional saturating hit counter built when HIT_COUNT_EN is defined.
module obstacle_hit_detector
   import obstacle_pkg::*;
#(
   parameter int D_WIDTH         = 640,
   parameter int D_HEIGHT        = 480,
   parameter int COOLDOWN_FRAMES = 30,
   parameter int CNT_W           = 8
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic               i_enable,
   input  logic               i_frame_stb,
   input  logic               i_clr,
   input  logic [COORD_W-1:0] i_obs_x1,
   input  logic [COORD_W-1:0] i_obs_x2,
   input  logic [COORD_W-1:0] i_obs_y1,
   input  logic [COORD_W-1:0] i_obs_y2,
   input  logic [COORD_W-1:0] i_ply_x1,
   input  logic [COORD_W-1:0] i_ply_x2,
   input  logic [COORD_W-1:0] i_ply_y1,
   input  logic [COORD_W-1:0] i_ply_y2,
   input  logic [COORD_W-1:0] i_pix_x,
   input  logic [COORD_W-1:0] i_pix_y,
   output logic               o_obs_px,
   output logic               o_ply_px,
   output logic               o_hit,
   output logic               o_hit_stb,
   output logic [CNT_W-1:0]   o_hit_count
);
   localparam int                CD_W    = $clog2(COOLDOWN_FRAMES + 1);
   localparam logic [CD_W-1:0]   CD_INIT = CD_W'(COOLDOWN_FRAMES);

   box_t w_obs_in, w_ply_in, w_obs, w_ply;
   logic w_obs_vis, w_ply_vis, w_overlap, w_hit_acc;

   assign w_obs_in = '{x1: i_obs_x1, x2: i_obs_x2, y1: i_obs_y1, y2: i_obs_y2};
   assign w_ply_in = '{x1: i_ply_x1, x2: i_ply_x2, y1: i_ply_y1, y2: i_ply_y2};

   box_clip_reg #(.D_WIDTH(D_WIDTH), .D_HEIGHT(D_HEIGHT)) u_obs (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_stb   (i_frame_stb),
      .i_box   (w_obs_in),
      .i_pix_x (i_pix_x),
      .i_pix_y (i_pix_y),
      .o_box   (w_obs),
      .o_vis   (w_obs_vis),
      .o_inside(o_obs_px)
   );

   box_clip_reg #(.D_WIDTH(D_WIDTH), .D_HEIGHT(D_HEIGHT)) u_ply (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_stb   (i_frame_stb),
      .i_box   (w_ply_in),
      .i_pix_x (i_pix_x),
      .i_pix_y (i_pix_y),
      .o_box   (w_ply),
      .o_vis   (w_ply_vis),
      .o_inside(o_ply_px)
   );

   assign w_overlap = w_obs_vis && w_ply_vis &&
                      (w_obs.x1 <= w_ply.x2) && (w_ply.x1 <= w_obs.x2) &&
                      (w_obs.y1 <= w_ply.y2) && (w_ply.y1 <= w_obs.y2);

   state_t          r_state;
   logic [CD_W-1:0] r_cd;
   logic            r_eval;
   logic            r_hit;
   logic            r_hit_stb;

   assign w_hit_acc = i_enable && (r_state == ARMED) && r_eval && w_overlap;

   // Clear is applied before a same-edge hit so the hit wins.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state   <= IDLE;
         r_cd      <= '0;
         r_eval    <= 1'b0;
         r_hit     <= 1'b0;
         r_hit_stb <= 1'b0;
      end else begin
         r_eval    <= i_frame_stb;
         r_hit_stb <= 1'b0;
         if (i_clr)
            r_hit <= 1'b0;
         if (!i_enable) begin
            r_state <= IDLE;
            r_cd    <= '0;
         end else begin
            case (r_state)
               IDLE: begin
                  if (i_frame_stb)
                     r_state <= ARMED;
               end
               ARMED: begin
                  if (r_eval && w_overlap) begin
                     r_state   <= COOLDOWN;
                     r_cd      <= CD_INIT;
                     r_hit_stb <= 1'b1;
                     r_hit     <= 1'b1;
                  end
               end
               COOLDOWN: begin
                  // Re-arm on the strobe that brings the count to zero, so that frame is evaluated.
                  if (i_frame_stb) begin
                     if (r_cd <= CD_W'(1)) begin
                        r_cd    <= '0;
                        r_state <= ARMED;
                     end else begin
                        r_cd <= r_cd - CD_W'(1);
                     end
                  end
               end
               default: r_state <= IDLE;
            endcase
         end
      end
   end

   assign o_hit     = r_hit;
   assign o_hit_stb = r_hit_stb;

`ifdef HIT_COUNT_EN
   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n)
         r_cnt <= '0;
      else if (i_clr)
         r_cnt <= w_hit_acc ? CNT_W'(1) : '0;
      else if (w_hit_acc && (r_cnt != {CNT_W{1'b1}}))
         r_cnt <= r_cnt + CNT_W'(1);
   end

   assign o_hit_count = r_cnt;
`else
   assign o_hit_count = '0;
`endif
endmodule
